// File: rtl/handshake_controller.sv
// One stage of a four-phase request/acknowledge ring: accepts a token from the
// predecessor, forwards it to the successor, then waits for both sides to return to zero.
module handshake_controller #(
  parameter bit INIT_TOKEN  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ack_i1,
  output logic req_i1,
  output logic ack_i
);

  // state | meaning
  // IDLE  | no token held; waiting for req_i with successor at zero
  // BUSY  | token held; waiting for successor ack and predecessor release
  // RTZ   | both sides released; waiting for successor ack to return to zero
  typedef enum logic [1:0] {IDLE, BUSY, RTZ} state_t;

  logic req_seen, ack_seen;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign req_seen = req_i;
      assign ack_seen = ack_i1;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] req_sync, ack_sync;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          req_sync <= '0;
          ack_sync <= '0;
        end else begin
          req_sync[0] <= req_i;
          ack_sync[0] <= ack_i1;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            req_sync[i] <= req_sync[i-1];
            ack_sync[i] <= ack_sync[i-1];
          end
        end
      end

      assign req_seen = req_sync[SYNC_STAGES-1];
      assign ack_seen = ack_sync[SYNC_STAGES-1];
    end
  endgenerate

  state_t state_q, state_d;
  logic   req_q, req_d, ack_q, ack_d;
  logic   dn_done_q, dn_done_d, up_done_q, up_done_d;

  // The initial token holder starts with nothing owed upstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT_TOKEN ? BUSY : IDLE;
      req_q     <= INIT_TOKEN;
      ack_q     <= 1'b0;
      dn_done_q <= 1'b0;
      up_done_q <= INIT_TOKEN;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      dn_done_q <= dn_done_d;
      up_done_q <= up_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    ack_d     = ack_q;
    dn_done_d = dn_done_q;
    up_done_d = up_done_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        ack_d = 1'b0;
        if (req_seen && !ack_seen) begin
          state_d   = BUSY;
          req_d     = 1'b1;
          ack_d     = 1'b1;
          dn_done_d = 1'b0;
          up_done_d = 1'b0;
        end
      end
      BUSY: begin
        if (ack_seen) begin
          dn_done_d = 1'b1;
          req_d     = 1'b0;
        end
        if (!req_seen) begin
          up_done_d = 1'b1;
          ack_d     = 1'b0;
        end
        if (dn_done_d && up_done_d) state_d = RTZ;
      end
      RTZ: begin
        req_d = 1'b0;
        ack_d = 1'b0;
        if (!ack_seen) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  assign req_i1 = req_q;
  assign ack_i  = ack_q;

endmodule

// File: tb/tb_handshake_controller.sv
// Bench for handshake_controller: three single stages checked every cycle against
// a phase-level model, plus a three-stage ring checked for token order and liveness.
module tb_handshake_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus: index 0 drives d0 and d2, index 1 drives d1.
  logic req_in [2];
  logic ack_in [2];
  logic d_req [3];
  logic d_ack [3];

  handshake_controller #(.INIT_TOKEN(1'b0), .SYNC_STAGES(2)) d0 (
    .clk(clk), .reset(reset), .req_i(req_in[0]), .ack_i1(ack_in[0]),
    .req_i1(d_req[0]), .ack_i(d_ack[0]));
  handshake_controller #(.INIT_TOKEN(1'b1), .SYNC_STAGES(1)) d1 (
    .clk(clk), .reset(reset), .req_i(req_in[1]), .ack_i1(ack_in[1]),
    .req_i1(d_req[1]), .ack_i(d_ack[1]));
  handshake_controller #(.INIT_TOKEN(1'b0), .SYNC_STAGES(0)) d2 (
    .clk(clk), .reset(reset), .req_i(req_in[0]), .ack_i1(ack_in[0]),
    .req_i1(d_req[2]), .ack_i(d_ack[2]));

  // Ring: stage k takes req from stage k-1 and ack from stage k+1.
  logic r_req [3];
  logic r_ack [3];
  handshake_controller #(.INIT_TOKEN(1'b1), .SYNC_STAGES(2)) r0 (
    .clk(clk), .reset(reset), .req_i(r_req[2]), .ack_i1(r_ack[1]),
    .req_i1(r_req[0]), .ack_i(r_ack[0]));
  handshake_controller #(.INIT_TOKEN(1'b0), .SYNC_STAGES(2)) r1 (
    .clk(clk), .reset(reset), .req_i(r_req[0]), .ack_i1(r_ack[2]),
    .req_i1(r_req[1]), .ack_i(r_ack[1]));
  handshake_controller #(.INIT_TOKEN(1'b0), .SYNC_STAGES(2)) r2 (
    .clk(clk), .reset(reset), .req_i(r_req[1]), .ack_i1(r_ack[0]),
    .req_i1(r_req[2]), .ack_i(r_ack[2]));

  // Model: a stage is busy while either output is high, RTZ is a single
  // pending flag, and the synchroniser is a history of sampled inputs.
  int NS [3]   = '{2, 1, 0};
  bit INIT [3] = '{1'b0, 1'b1, 1'b0};
  int SRC [3]  = '{0, 1, 0};
  bit m_req [3];
  bit m_ack [3];
  bit m_rtz [3];
  bit hr [3][4];
  bit ha [3][4];

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_req[k] = INIT[k];
      m_ack[k] = 1'b0;
      m_rtz[k] = 1'b0;
      for (int j = 0; j < 4; j++) begin
        hr[k][j] = 1'b0;
        ha[k][j] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    bit s_req, s_ack;
    for (int k = 0; k < 3; k++) begin
      hr[k][0] = req_in[SRC[k]];
      ha[k][0] = ack_in[SRC[k]];
      s_req = hr[k][NS[k]];
      s_ack = ha[k][NS[k]];
      if (m_rtz[k]) begin
        if (!s_ack) m_rtz[k] = 1'b0;
      end else if (m_req[k] || m_ack[k]) begin
        if (s_ack) m_req[k] = 1'b0;
        if (!s_req) m_ack[k] = 1'b0;
        if (!m_req[k] && !m_ack[k]) m_rtz[k] = 1'b1;
      end else if (s_req && !s_ack) begin
        m_req[k] = 1'b1;
        m_ack[k] = 1'b1;
      end
      for (int j = 3; j > 0; j--) begin
        hr[k][j] = hr[k][j-1];
        ha[k][j] = ha[k][j-1];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model d%0d req_i1", k), d_req[k], m_req[k]);
      chk($sformatf("model d%0d ack_i", k), d_ack[k], m_ack[k]);
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int cnt [3];
  bit prev [3];
  int falls;
  int highs;
  int cyc;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_in[k] = 1'b0;
      ack_in[k] = 1'b0;
    end
    model_reset();
    steps(2);
    reset = 1'b0;
    step();
    chk("reset d0 req_i1", d_req[0], 0);
    chk("reset d0 ack_i", d_ack[0], 0);
    chk("reset d1 req_i1", d_req[1], 1);
    chk("reset d1 ack_i", d_ack[1], 0);

    // Single handshake on d0, latency SYNC_STAGES+1 = 3 edges.
    req_in[0] = 1'b1;
    steps(2);
    chk("fwd early req_i1", d_req[0], 0);
    step();
    chk("fwd req_i1", d_req[0], 1);
    chk("fwd ack_i", d_ack[0], 1);
    ack_in[0] = 1'b1;
    steps(2);
    chk("dn early req_i1", d_req[0], 1);
    step();
    chk("dn req_i1", d_req[0], 0);
    chk("dn ack_i held", d_ack[0], 1);
    req_in[0] = 1'b0;
    steps(2);
    chk("up early ack_i", d_ack[0], 1);
    step();
    chk("up ack_i", d_ack[0], 0);
    ack_in[0] = 1'b0;
    steps(4);

    // Simultaneous release.
    req_in[0] = 1'b1;
    steps(3);
    req_in[0] = 1'b0;
    ack_in[0] = 1'b1;
    steps(2);
    chk("sim early req_i1", d_req[0], 1);
    chk("sim early ack_i", d_ack[0], 1);
    step();
    chk("sim req_i1", d_req[0], 0);
    chk("sim ack_i", d_ack[0], 0);
    ack_in[0] = 1'b0;
    steps(4);

    // Blocked forward: successor still acknowledging.
    ack_in[0] = 1'b1;
    steps(4);
    req_in[0] = 1'b1;
    steps(6);
    chk("blocked req_i1", d_req[0], 0);
    chk("blocked ack_i", d_ack[0], 0);
    ack_in[0] = 1'b0;
    steps(2);
    chk("unblock early req_i1", d_req[0], 0);
    step();
    chk("unblock req_i1", d_req[0], 1);
    ack_in[0] = 1'b1;
    steps(3);
    req_in[0] = 1'b0;
    steps(3);
    ack_in[0] = 1'b0;
    steps(4);

    // Initial token holder (d1, one sync stage).
    ack_in[1] = 1'b1;
    step();
    chk("init early req_i1", d_req[1], 1);
    step();
    chk("init req_i1 drop", d_req[1], 0);
    chk("init ack_i", d_ack[1], 0);
    ack_in[1] = 1'b0;
    steps(3);
    req_in[1] = 1'b1;
    steps(2);
    chk("init next req_i1", d_req[1], 1);
    chk("init next ack_i", d_ack[1], 1);

    // Asynchronous reset while d0 is busy.
    req_in[0] = 1'b1;
    steps(3);
    chk("pre-reset req_i1", d_req[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset d0 req_i1", d_req[0], 0);
    chk("async reset d0 ack_i", d_ack[0], 0);
    chk("async reset d1 req_i1", d_req[1], 1);
    chk("async reset d1 ack_i", d_ack[1], 0);
    model_reset();
    req_in[0] = 1'b0;
    req_in[1] = 1'b0;
    ack_in[0] = 1'b0;
    ack_in[1] = 1'b0;
    steps(2);
    reset = 1'b0;
    steps(3);
    chk("post-reset idle req_i1", d_req[0], 0);

    // Randomised inputs, including protocol violations.
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(3) == 0) req_in[k] = ~req_in[k];
        if ($urandom_range(3) == 0) ack_in[k] = ~ack_in[k];
      end
    end
    req_in[0] = 1'b0;
    req_in[1] = 1'b0;
    ack_in[0] = 1'b0;
    ack_in[1] = 1'b0;
    steps(5);

    // Ring: fresh reset, then 30 laps.
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      cnt[s] = 0;
      prev[s] = 1'b0;
    end
    falls = 0;
    cyc = 0;
    while (cyc < 20000 && cnt[2] < 30) begin
      step();
      cyc++;
      highs = 0;
      for (int s = 0; s < 3; s++) begin
        if (r_req[s]) highs++;
        if (prev[s] && !r_req[s]) begin
          chk("ring order", s, falls % 3);
          falls++;
          cnt[s]++;
        end
        prev[s] = r_req[s];
      end
      chk("ring req high count <= 2", (highs <= 2) ? 1 : 0, 1);
    end
    chk("ring laps stage 2", cnt[2], 30);
    chk("ring laps stage 1", cnt[1], 30);
    chk("ring laps stage 0", cnt[0], 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
